// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder: CPU-facing MMIO block with an RX byte FIFO, a TX holding register and cycle/instruction counters
module mmio_uart_responder #(
  parameter int         RX_DEPTH = 4,
  parameter logic [3:0] IO_BASE  = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int AW = $clog2(RX_DEPTH);
  logic [7:0]    fifo [RX_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          tx_full;
  logic [7:0]    tx_buf;
  logic [31:0]   cycle_cnt, inst_cnt, rd_val;
  logic [5:0]    word;
  logic          sel, empty, full, push, pop, tx_st, tx_hs, clr;
  logic          unused_bits;
  assign unused_bits = ^{addr[27:8], addr[1:0], wdata[31:8]};
  always_comb begin
    sel   = addr[31:28] == IO_BASE;
    word  = addr[7:2];
    empty = count == '0;
    full  = count == (AW+1)'(RX_DEPTH);
    push  = uart_rx_valid && !full;
    pop   = sel && re && word == 6'h01 && !empty;
    tx_st = sel && wbe[0] && word == 6'h02;
    tx_hs = tx_full && uart_tx_ready;
    clr   = sel && |wbe && word == 6'h06;
    rd_val = !sel          ? 32'h0 :
             word == 6'h00 ? {30'b0, !empty, !tx_full} :
             word == 6'h01 ? (empty ? 32'h0 : {24'b0, fifo[rd_ptr]}) :
             word == 6'h04 ? cycle_cnt :
             word == 6'h05 ? inst_cnt : 32'h0;
  end
  assign uart_rx_ready = !full;
  assign uart_tx_valid = tx_full;
  assign uart_tx_data  = tx_buf;
  // FIFO storage needs no reset; the pointers and count define validity
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= uart_rx_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tx_full   <= 1'b0;
      tx_buf    <= '0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (re) rdata <= rd_val;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (tx_st && (!tx_full || tx_hs)) begin
        tx_buf  <= wdata[7:0];
        tx_full <= 1'b1;
      end else if (tx_hs) tx_full <= 1'b0;
      cycle_cnt <= clr ? 32'h0 : cycle_cnt + 32'd1;
      inst_cnt  <= clr ? 32'h0 : inst_cnt + 32'(inst_retire);
    end
  end
endmodule

// File: tb/tb_mmio_uart_responder.sv
// tb_mmio_uart_responder: directed vector table plus hand sequences for FIFO, TX, counter and reset corners
module tb_mmio_uart_responder;
  localparam logic [31:0] IO = 32'h8000_0000;
  logic        clk = 0, rst = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0]  wbe = 0;
  logic        re = 0, inst_retire = 0;
  logic [7:0]  uart_tx_data, uart_rx_data = 0;
  logic        uart_tx_valid, uart_tx_ready = 0, uart_rx_valid = 0, uart_rx_ready;
  int n_run = 0, n_fail = 0;
  mmio_uart_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wbe(wbe), .re(re), .rdata(rdata),
    .inst_retire(inst_retire), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    string       nm;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        r, rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [31:0] e_rd;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_rxr;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic r, input logic rxv, input logic [7:0] rxd, input logic txr);
    @(negedge clk);
    addr = a; wdata = wd; wbe = be; re = r;
    uart_rx_valid = rxv; uart_rx_data = rxd; uart_tx_ready = txr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v.push_back('{"status_after_reset", IO,        32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"tx_store_41",        IO + 8,    32'h41, 4'h1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1, 1'b1, 8'h41, 1'b1});
    v.push_back('{"tx_store_42_drop",   IO + 8,    32'h42, 4'h1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1, 1'b1, 8'h41, 1'b1});
    v.push_back('{"tx_handshake",       IO,        32'h0,  4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"status_tx_free",     IO,        32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"push_10",            IO,        32'h0,  4'h0, 1'b0, 1'b1, 8'h10, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"push_11",            IO,        32'h0,  4'h0, 1'b0, 1'b1, 8'h11, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"push_12",            IO,        32'h0,  4'h0, 1'b0, 1'b1, 8'h12, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"push_13_full",       IO,        32'h0,  4'h0, 1'b0, 1'b1, 8'h13, 1'b0, 32'h1, 1'b0, 8'h00, 1'b0});
    v.push_back('{"status_full",        IO,        32'h0,  4'h0, 1'b1, 1'b1, 8'hEE, 1'b0, 32'h3, 1'b0, 8'h00, 1'b0});
    v.push_back('{"pop_10",             IO + 4,    32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h10, 1'b0, 8'h00, 1'b1});
    v.push_back('{"pop_11",             IO + 4,    32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h11, 1'b0, 8'h00, 1'b1});
    v.push_back('{"pop_12",             IO + 4,    32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h12, 1'b0, 8'h00, 1'b1});
    v.push_back('{"pop_13",             IO + 4,    32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h13, 1'b0, 8'h00, 1'b1});
    v.push_back('{"pop_empty",          IO + 4,    32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00, 1'b1});
    v.push_back('{"status_empty",       IO,        32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"unmapped_read",      IO + 12,   32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00, 1'b1});
    v.push_back('{"unselected_read",    32'h9000_0000, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00, 1'b1});
    v.push_back('{"low_bits_ignored",   IO + 2,    32'h0,  4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"rdata_hold",         IO + 16,   32'h0,  4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"unmapped_store",     IO + 32,   32'hAA, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    v.push_back('{"tx_store_no_wbe0",   IO + 8,    32'h5A, 4'h2, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1, 1'b0, 8'h00, 1'b1});
    cyc(IO, 0, 0, 0, 0, 0, 0);
    cyc(IO, 0, 0, 0, 0, 0, 0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("reset_rx_ready", 32'(uart_rx_ready), 32'h1);
    rst = 1;
    foreach (v[i]) begin
      cyc(v[i].a, v[i].wd, v[i].be, v[i].r, v[i].rxv, v[i].rxd, v[i].txr);
      chk({v[i].nm, "_rdata"}, rdata, v[i].e_rd);
      chk({v[i].nm, "_tx_valid"}, 32'(uart_tx_valid), 32'(v[i].e_txv));
      chk({v[i].nm, "_rx_ready"}, 32'(uart_rx_ready), 32'(v[i].e_rxr));
      if (v[i].e_txv) chk({v[i].nm, "_tx_data"}, 32'(uart_tx_data), 32'(v[i].e_txd));
    end
    for (int i = 0; i < 3; i++) cyc(IO, 0, 0, 0, 1, 8'(8'h20 + i), 0);
    cyc(IO + 4, 0, 0, 1, 1, 8'h23, 0);
    chk("pushpop_rdata", rdata, 32'h20);
    chk("pushpop_rx_ready", 32'(uart_rx_ready), 32'h1);
    for (int i = 1; i < 4; i++) begin
      cyc(IO + 4, 0, 0, 1, 0, 0, 0);
      chk("pushpop_order", rdata, 32'h20 + 32'(i));
    end
    cyc(IO + 4, 0, 0, 1, 0, 0, 0);
    chk("pushpop_drained", rdata, 32'h0);
    cyc(IO + 4, 0, 0, 1, 1, 8'h30, 0);
    chk("empty_pop_with_push", rdata, 32'h0);
    cyc(IO + 4, 0, 0, 1, 0, 0, 0);
    chk("byte_after_empty_push", rdata, 32'h30);
    cyc(IO + 8, 32'h55, 4'h1, 0, 0, 0, 0);
    chk("tx_pend_55", 32'(uart_tx_data), 32'h55);
    cyc(IO + 8, 32'h66, 4'h1, 0, 0, 0, 1);
    chk("tx_hs_store_valid", 32'(uart_tx_valid), 32'h1);
    chk("tx_hs_store_data", 32'(uart_tx_data), 32'h66);
    cyc(IO, 0, 0, 0, 0, 0, 1);
    chk("tx_hs_final", 32'(uart_tx_valid), 32'h0);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt;
    cyc(IO, 0, 0, 0, 0, 0, 0);
    cyc(IO, 0, 0, 0, 0, 0, 0);
    cyc(IO + 16, 0, 0, 1, 0, 0, 0);
    chk("cycle_wrap", rdata, 32'h0);
    inst_retire = 1;
    for (int i = 0; i < 3; i++) cyc(IO, 0, 0, 0, 0, 0, 0);
    inst_retire = 0;
    cyc(IO + 20, 0, 0, 1, 0, 0, 0);
    chk("inst_count", rdata, 32'h3);
    inst_retire = 1;
    cyc(IO + 24, 0, 4'h2, 0, 0, 0, 0);
    inst_retire = 0;
    cyc(IO + 20, 0, 0, 1, 0, 0, 0);
    chk("inst_cleared", rdata, 32'h0);
    cyc(IO + 16, 0, 0, 1, 0, 0, 0);
    chk("cycle_after_clear", rdata, 32'h1);
    cyc(IO + 8, 32'h99, 4'h1, 0, 0, 0, 0);
    cyc(IO, 0, 0, 0, 1, 8'h44, 0);
    cyc(IO, 0, 0, 0, 1, 8'h45, 0);
    chk("pre_reset_tx_valid", 32'(uart_tx_valid), 32'h1);
    rst = 0;
    cyc(IO, 0, 0, 0, 0, 0, 0);
    rst = 1;
    chk("midreset_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("midreset_rx_ready", 32'(uart_rx_ready), 32'h1);
    cyc(IO, 0, 0, 1, 0, 0, 0);
    chk("midreset_status", rdata, 32'h1);
    cyc(IO + 4, 0, 0, 1, 0, 0, 0);
    chk("midreset_rx_read", rdata, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
